// File: rtl/alsu_pkg.sv
// Shared definitions for the ALSU carry-chain sequencer and the ALSU select decode.
// Optional feature macro: CARRY_CHAIN_OVF_EN (signed overflow flag).
package alsu_pkg;

    // ALSU select codes, kept identical to the ALSU's own select decode
    localparam logic [3:0] SEL_ADD = 4'b0000;
    localparam logic [3:0] SEL_INC = 4'b1110;

    // Operation codes presented by the system controller
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_INC = 1'b1;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // Width of the nibble index; a one-nibble chain still gets a 1-bit index
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/alsu_carry_chain_sequencer_if.sv
// Bus between system controller / ALSU slice and the carry-chain sequencer.
// Optional feature macro: CARRY_CHAIN_OVF_EN (affects the Overflow signal only).
interface alsu_carry_chain_sequencer_if #(
    parameter int NIBBLES = 4
);
    // Controller request side
    logic                   Start;
    logic                   Op;
    logic [4*NIBBLES-1:0]   A;
    logic [4*NIBBLES-1:0]   B;
    logic                   Carry_In;

    // ALSU slice side
    logic [3:0]             Alsu_A;
    logic [3:0]             Alsu_B;
    logic [3:0]             Alsu_Sel;
    logic                   Alsu_Carry_In;
    logic [3:0]             Alsu_Result;
    logic                   Alsu_Carry_Out;

    // Status / result side
    logic                   Busy;
    logic                   Done;
    logic [4*NIBBLES-1:0]   Result;
    logic                   Carry_Out;
    logic                   Zero;
    logic                   Overflow;

    // Sequencer view
    modport slave (
        input  Start, Op, A, B, Carry_In, Alsu_Result, Alsu_Carry_Out,
        output Alsu_A, Alsu_B, Alsu_Sel, Alsu_Carry_In,
        output Busy, Done, Result, Carry_Out, Zero, Overflow
    );

    // Controller + ALSU view
    modport master (
        output Start, Op, A, B, Carry_In, Alsu_Result, Alsu_Carry_Out,
        input  Alsu_A, Alsu_B, Alsu_Sel, Alsu_Carry_In,
        input  Busy, Done, Result, Carry_Out, Zero, Overflow
    );

endinterface

// File: rtl/alsu_nibble_mux.sv
// Picks nibble[idx] of the latched operands and generates the ALSU select and
// carry-in for the current step of the chain. Everything is zero outside RUN.
// Optional feature macro: CARRY_CHAIN_OVF_EN (not used here).
module alsu_nibble_mux
    import alsu_pkg::*;
#(
    parameter int NIBBLES = 4,
    parameter int IDX_W   = 2
) (
    input  logic                  run_i,
    input  logic                  op_i,
    input  logic [IDX_W-1:0]      idx_i,
    input  logic [4*NIBBLES-1:0]  a_i,
    input  logic [4*NIBBLES-1:0]  b_i,
    input  logic                  carry_i,
    output logic [3:0]            alsu_a_o,
    output logic [3:0]            alsu_b_o,
    output logic [3:0]            alsu_sel_o,
    output logic                  alsu_cin_o
);

    logic [3:0] a_nib [NIBBLES];
    logic [3:0] b_nib [NIBBLES];

    // Split operands into per-slice nibbles
    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_split
            assign a_nib[gi] = a_i[4*gi +: 4];
            assign b_nib[gi] = b_i[4*gi +: 4];
        end
    endgenerate

    // Increment uses the ALSU's native increment only on nibble 0; the upper
    // nibbles ripple the carry through a plain add with B forced to zero.
    always_comb begin
        alsu_a_o   = 4'b0000;
        alsu_b_o   = 4'b0000;
        alsu_sel_o = SEL_ADD;
        alsu_cin_o = 1'b0;
        if (run_i) begin
            alsu_a_o = a_nib[idx_i];
            if (op_i == OP_INC) begin
                alsu_b_o = 4'b0000;
                if (idx_i == '0) begin
                    alsu_sel_o = SEL_INC;
                    alsu_cin_o = 1'b0;
                end else begin
                    alsu_sel_o = SEL_ADD;
                    alsu_cin_o = carry_i;
                end
            end else begin
                alsu_b_o   = b_nib[idx_i];
                alsu_sel_o = SEL_ADD;
                alsu_cin_o = carry_i;
            end
        end
    end

endmodule

// File: rtl/alsu_carry_chain_sequencer.sv
// Sequences a wide add / increment through a combinational 4-bit ALSU slice,
// one nibble per clock, feeding the slice carry-out back as the next carry-in.
// Optional feature macro: CARRY_CHAIN_OVF_EN enables the signed Overflow flag;
// without it Overflow is tied low and no sign state is kept.
module alsu_carry_chain_sequencer
    import alsu_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic CLK,
    input  logic RST_N,
    alsu_carry_chain_sequencer_if.slave bus
);

    localparam int               W        = 4 * NIBBLES;
    localparam int               IDX_W    = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    seq_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic              op_q, op_d;
    logic [W-1:0]      result_q, result_d;
    logic              carry_out_q, carry_out_d;
    logic              zero_q, zero_d;
`ifdef CARRY_CHAIN_OVF_EN
    logic              ovf_q, ovf_d;
    logic              b_msb;
`endif

    logic [3:0]        mux_a, mux_b, mux_sel;
    logic              mux_cin;

    alsu_nibble_mux #(
        .NIBBLES (NIBBLES),
        .IDX_W   (IDX_W)
    ) u_nibble_mux (
        .run_i      (state_q == ST_RUN),
        .op_i       (op_q),
        .idx_i      (idx_q),
        .a_i        (a_q),
        .b_i        (b_q),
        .carry_i    (carry_q),
        .alsu_a_o   (mux_a),
        .alsu_b_o   (mux_b),
        .alsu_sel_o (mux_sel),
        .alsu_cin_o (mux_cin)
    );

`ifdef CARRY_CHAIN_OVF_EN
    // Effective B sign bit: increment behaves as A + 0 with an injected carry
    assign b_msb = (op_q == OP_INC) ? 1'b0 : b_q[W-1];
`endif

    // Next-state: accept in IDLE, collect one nibble per RUN cycle, flags on the last one
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        zero_d      = zero_q;
`ifdef CARRY_CHAIN_OVF_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                    a_d     = bus.A;
                    b_d     = bus.B;
                    op_d    = bus.Op;
                    carry_d = (bus.Op == OP_ADD) ? bus.Carry_In : 1'b0;
                end
            end
            ST_RUN: begin
                result_d[4*idx_q +: 4] = bus.Alsu_Result;
                carry_d                = bus.Alsu_Carry_Out;
                if (idx_q == IDX_LAST) begin
                    // Flags are registered here so they are already valid while Done is high
                    state_d     = ST_DONE;
                    idx_d       = '0;
                    carry_out_d = bus.Alsu_Carry_Out;
                    zero_d      = (result_d == '0);
`ifdef CARRY_CHAIN_OVF_EN
                    ovf_d       = (a_q[W-1] == b_msb) && (bus.Alsu_Result[3] != a_q[W-1]);
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset discards any partial operation
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_ADD;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            zero_q      <= 1'b0;
`ifdef CARRY_CHAIN_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            zero_q      <= zero_d;
`ifdef CARRY_CHAIN_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign bus.Alsu_A        = mux_a;
    assign bus.Alsu_B        = mux_b;
    assign bus.Alsu_Sel      = mux_sel;
    assign bus.Alsu_Carry_In = mux_cin;

    assign bus.Busy      = (state_q != ST_IDLE);
    assign bus.Done      = (state_q == ST_DONE);
    assign bus.Result    = result_q;
    assign bus.Carry_Out = carry_out_q;
    assign bus.Zero      = zero_q;
`ifdef CARRY_CHAIN_OVF_EN
    assign bus.Overflow  = ovf_q;
`else
    assign bus.Overflow  = 1'b0;
`endif

endmodule
